// File: rtl/usr_lpbk_sel.sv
// usr_lpbk_sel: runtime-selectable path between XDMA stream port 0 and user logic.
//   Modes: 00 normal pass-through, 01 buffered loopback (H2C -> FIFO -> C2H),
//   10 H2C drop/sink, 11 treated as 00. Mode changes wait for packet boundaries
//   and an empty loopback FIFO (DRAIN state, busy_o high).
// Ports:
//   sys_clk_i, sys_rst_i     clock, synchronous active-high reset
//   mode_i, cnt_clr_i        requested mode, counter/error clear
//   act_mode_o, busy_o       mode in force, switch pending
//   fifo_lvl_o               loopback FIFO occupancy
//   h2c_pkt_cnt_o, c2h_pkt_cnt_o  packet counters (tlast handshakes)
//   err_o                    sticky tkeep error in loopback
//   m0_axis_h2c_*            XDMA H2C stream in
//   m0_axis_h2ca_*           gated H2C to user sink (data taken from H2C bus)
//   s0_axis_c2ha_*           user C2H source in
//   s0_axis_c2h_*            C2H stream to XDMA
// Optional: define USR_LPBK_ERR_CHK_EN to build the loopback tkeep check;
//   otherwise err_o is tied low.
module usr_lpbk_sel #(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned KEEP_W     = DATA_W / 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic [1:0]                    mode_i,
  input  logic                          cnt_clr_i,
  output logic [1:0]                    act_mode_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl_o,
  output logic [CNT_W-1:0]              h2c_pkt_cnt_o,
  output logic [CNT_W-1:0]              c2h_pkt_cnt_o,
  output logic                          err_o,
  input  logic [DATA_W-1:0]             m0_axis_h2c_tdata_i,
  input  logic [KEEP_W-1:0]             m0_axis_h2c_tkeep_i,
  input  logic [KEEP_W-1:0]             m0_axis_h2c_tuser_i,
  input  logic                          m0_axis_h2c_tlast_i,
  input  logic                          m0_axis_h2c_tvalid_i,
  output logic                          m0_axis_h2c_tready_o,
  output logic                          m0_axis_h2ca_tvalid_o,
  input  logic                          m0_axis_h2ca_tready_i,
  input  logic [DATA_W-1:0]             s0_axis_c2ha_tdata_i,
  input  logic [KEEP_W-1:0]             s0_axis_c2ha_tkeep_i,
  input  logic [KEEP_W-1:0]             s0_axis_c2ha_tuser_i,
  input  logic                          s0_axis_c2ha_tlast_i,
  input  logic                          s0_axis_c2ha_tvalid_i,
  output logic                          s0_axis_c2ha_tready_o,
  output logic [DATA_W-1:0]             s0_axis_c2h_tdata_o,
  output logic [KEEP_W-1:0]             s0_axis_c2h_tkeep_o,
  output logic [KEEP_W-1:0]             s0_axis_c2h_tuser_o,
  output logic                          s0_axis_c2h_tlast_o,
  output logic                          s0_axis_c2h_tvalid_o,
  input  logic                          s0_axis_c2h_tready_i
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = DATA_W + 2 * KEEP_W + 1;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ModeNorm = 2'b00;
  localparam logic [1:0] ModeLpbk = 2'b01;
  localparam logic [1:0] ModeDrop = 2'b10;

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e      state_q, state_d;
  logic [1:0]  act_mode_q, act_mode_d;
  logic [1:0]  mode_req_q, mode_req_d;
  logic [1:0]  mode_sel;
  logic        h2c_in_pkt_q, c2h_out_pkt_q;
  logic        h2c_block, c2h_block;
  logic        h2c_hs, c2h_hs, fifo_wr, fifo_rd;
  logic        fifo_empty, fifo_full;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   lvl_q;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] head;
  logic [CNT_W-1:0] h2c_cnt_q, c2h_cnt_q;

  assign mode_sel   = (mode_i == 2'b11) ? ModeNorm : mode_i;
  assign fifo_empty = (lvl_q == '0);
  assign fifo_full  = (lvl_q == FULL_LVL);
  assign head       = mem_q[rd_ptr_q];

  // While draining, only the packet already in flight on each side may move.
  assign h2c_block = (state_q == StDrain) && !h2c_in_pkt_q;
  assign c2h_block = (state_q == StDrain) && !c2h_out_pkt_q;

  // Mode FSM
  always_comb begin
    state_d    = state_q;
    act_mode_d = act_mode_q;
    mode_req_d = mode_req_q;
    case (state_q)
      StRun: begin
        if (mode_sel != act_mode_q) begin
          mode_req_d = mode_sel;
          state_d    = StDrain;
        end
      end
      default: begin
        if (!h2c_in_pkt_q && !c2h_out_pkt_q && fifo_empty) begin
          act_mode_d = mode_req_q;
          state_d    = StRun;
        end
      end
    endcase
  end

  // Stream steering
  always_comb begin
    m0_axis_h2c_tready_o  = 1'b0;
    m0_axis_h2ca_tvalid_o = 1'b0;
    s0_axis_c2ha_tready_o = 1'b0;
    s0_axis_c2h_tdata_o   = s0_axis_c2ha_tdata_i;
    s0_axis_c2h_tkeep_o   = s0_axis_c2ha_tkeep_i;
    s0_axis_c2h_tuser_o   = s0_axis_c2ha_tuser_i;
    s0_axis_c2h_tlast_o   = s0_axis_c2ha_tlast_i;
    s0_axis_c2h_tvalid_o  = 1'b0;
    case (act_mode_q)
      ModeLpbk: begin
        // A full FIFO still takes a beat when its head leaves in the same cycle.
        m0_axis_h2c_tready_o = !h2c_block && (!fifo_full || s0_axis_c2h_tready_i);
        {s0_axis_c2h_tdata_o, s0_axis_c2h_tkeep_o, s0_axis_c2h_tuser_o,
         s0_axis_c2h_tlast_o} = head;
        s0_axis_c2h_tvalid_o = !fifo_empty;
      end
      ModeDrop: begin
        m0_axis_h2c_tready_o  = !h2c_block;
        s0_axis_c2h_tvalid_o  = s0_axis_c2ha_tvalid_i && !c2h_block;
        s0_axis_c2ha_tready_o = s0_axis_c2h_tready_i && !c2h_block;
      end
      default: begin
        m0_axis_h2ca_tvalid_o = m0_axis_h2c_tvalid_i && !h2c_block;
        m0_axis_h2c_tready_o  = m0_axis_h2ca_tready_i && !h2c_block;
        s0_axis_c2h_tvalid_o  = s0_axis_c2ha_tvalid_i && !c2h_block;
        s0_axis_c2ha_tready_o = s0_axis_c2h_tready_i && !c2h_block;
      end
    endcase
    if (sys_rst_i) begin
      m0_axis_h2c_tready_o  = 1'b0;
      m0_axis_h2ca_tvalid_o = 1'b0;
      s0_axis_c2ha_tready_o = 1'b0;
      s0_axis_c2h_tvalid_o  = 1'b0;
    end
  end

  assign h2c_hs  = m0_axis_h2c_tvalid_i && m0_axis_h2c_tready_o;
  assign c2h_hs  = s0_axis_c2h_tvalid_o && s0_axis_c2h_tready_i;
  assign fifo_wr = h2c_hs && (act_mode_q == ModeLpbk);
  assign fifo_rd = c2h_hs && (act_mode_q == ModeLpbk);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q       <= StRun;
      act_mode_q    <= ModeNorm;
      mode_req_q    <= ModeNorm;
      h2c_in_pkt_q  <= 1'b0;
      c2h_out_pkt_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      lvl_q         <= '0;
    end else begin
      state_q    <= state_d;
      act_mode_q <= act_mode_d;
      mode_req_q <= mode_req_d;
      if (h2c_hs) h2c_in_pkt_q  <= !m0_axis_h2c_tlast_i;
      if (c2h_hs) c2h_out_pkt_q <= !s0_axis_c2h_tlast_o;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= {m0_axis_h2c_tdata_i, m0_axis_h2c_tkeep_i,
                          m0_axis_h2c_tuser_i, m0_axis_h2c_tlast_i};
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i || cnt_clr_i) begin
      h2c_cnt_q <= '0;
      c2h_cnt_q <= '0;
    end else begin
      if (h2c_hs && m0_axis_h2c_tlast_i) h2c_cnt_q <= h2c_cnt_q + 1'b1;
      if (c2h_hs && s0_axis_c2h_tlast_o) c2h_cnt_q <= c2h_cnt_q + 1'b1;
    end
  end

`ifdef USR_LPBK_ERR_CHK_EN
  logic err_q;
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i || cnt_clr_i) begin
      err_q <= 1'b0;
    end else if (fifo_wr && !m0_axis_h2c_tlast_i && (m0_axis_h2c_tkeep_i != '1)) begin
      err_q <= 1'b1;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign act_mode_o    = act_mode_q;
  assign busy_o        = (state_q == StDrain);
  assign fifo_lvl_o    = lvl_q;
  assign h2c_pkt_cnt_o = h2c_cnt_q;
  assign c2h_pkt_cnt_o = c2h_cnt_q;

endmodule

// File: tb/tb_usr_lpbk_sel.sv
module tb_usr_lpbk_sel;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = 4;
  localparam int unsigned FD = 16;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic cnt_clr = 1'b0;
  logic [1:0] act_mode;
  logic busy;
  logic [4:0] fifo_lvl;
  logic [CW-1:0] h2c_cnt, c2h_cnt;
  logic err;
  logic [DW-1:0] h2c_tdata = '0;
  logic [KW-1:0] h2c_tkeep = '0, h2c_tuser = '0;
  logic h2c_tlast = 1'b0, h2c_tvalid = 1'b0, h2c_tready;
  logic h2ca_tvalid, h2ca_tready = 1'b0;
  logic [DW-1:0] c2ha_tdata = '0;
  logic [KW-1:0] c2ha_tkeep = '0, c2ha_tuser = '0;
  logic c2ha_tlast = 1'b0, c2ha_tvalid = 1'b0, c2ha_tready;
  logic [DW-1:0] c2h_tdata;
  logic [KW-1:0] c2h_tkeep, c2h_tuser;
  logic c2h_tlast, c2h_tvalid, c2h_tready = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  usr_lpbk_sel #(.DATA_W(DW), .KEEP_W(KW), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .mode_i(mode), .cnt_clr_i(cnt_clr),
    .act_mode_o(act_mode), .busy_o(busy), .fifo_lvl_o(fifo_lvl),
    .h2c_pkt_cnt_o(h2c_cnt), .c2h_pkt_cnt_o(c2h_cnt), .err_o(err),
    .m0_axis_h2c_tdata_i(h2c_tdata), .m0_axis_h2c_tkeep_i(h2c_tkeep),
    .m0_axis_h2c_tuser_i(h2c_tuser), .m0_axis_h2c_tlast_i(h2c_tlast),
    .m0_axis_h2c_tvalid_i(h2c_tvalid), .m0_axis_h2c_tready_o(h2c_tready),
    .m0_axis_h2ca_tvalid_o(h2ca_tvalid), .m0_axis_h2ca_tready_i(h2ca_tready),
    .s0_axis_c2ha_tdata_i(c2ha_tdata), .s0_axis_c2ha_tkeep_i(c2ha_tkeep),
    .s0_axis_c2ha_tuser_i(c2ha_tuser), .s0_axis_c2ha_tlast_i(c2ha_tlast),
    .s0_axis_c2ha_tvalid_i(c2ha_tvalid), .s0_axis_c2ha_tready_o(c2ha_tready),
    .s0_axis_c2h_tdata_o(c2h_tdata), .s0_axis_c2h_tkeep_o(c2h_tkeep),
    .s0_axis_c2h_tuser_o(c2h_tuser), .s0_axis_c2h_tlast_o(c2h_tlast),
    .s0_axis_c2h_tvalid_o(c2h_tvalid), .s0_axis_c2h_tready_i(c2h_tready)
  );

  // Request a mode and wait (bounded) until it is in force.
  task automatic set_mode(input logic [1:0] m, input logic [1:0] exp, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    mode = m;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      #1;
      ok = (act_mode === exp) && (busy === 1'b0);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    h2c_tvalid = 1'b1; c2ha_tvalid = 1'b1; h2ca_tready = 1'b1; c2h_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if ({h2c_tready, h2ca_tvalid, c2ha_tready, c2h_tvalid} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_gate: got h2c_rdy/h2ca_vld/c2ha_rdy/c2h_vld=%b want 0000",
               {h2c_tready, h2ca_tvalid, c2ha_tready, c2h_tvalid});
    end
    h2c_tvalid = 1'b0; c2ha_tvalid = 1'b0; h2ca_tready = 1'b0; c2h_tready = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (act_mode !== 2'b00 || busy !== 1'b0 || fifo_lvl !== 5'd0 || h2c_cnt !== 3'd0 ||
        c2h_cnt !== 3'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got mode=%b busy=%b lvl=%0d h2c=%0d c2h=%0d err=%b want 00 0 0 0 0 0",
               act_mode, busy, fifo_lvl, h2c_cnt, c2h_cnt, err);
    end
  endtask

  task automatic test_normal();
    logic [DW-1:0] d;
    h2ca_tready = 1'b1; c2h_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d = 32'hA5A5_0000 + 32'(i);
      c2ha_tdata = d; c2ha_tkeep = 4'hF; c2ha_tuser = 4'(i);
      c2ha_tlast = (i == 3); c2ha_tvalid = 1'b1;
      #1;
      total++;
      if (c2h_tdata !== d || c2h_tuser !== 4'(i) || c2h_tvalid !== 1'b1 ||
          c2h_tlast !== (i == 3) || c2ha_tready !== 1'b1) begin
        bad++;
        $display("FAIL normal_c2h beat %0d: got data=%h user=%h vld=%b last=%b rdy=%b want %h %h 1 %b 1",
                 i, c2h_tdata, c2h_tuser, c2h_tvalid, c2h_tlast, c2ha_tready, d, 4'(i), i == 3);
      end
    end
    @(negedge clk);
    c2ha_tvalid = 1'b0; c2ha_tlast = 1'b0; c2h_tready = 1'b0;
    #1;
    total++;
    if (c2h_cnt !== 3'd1 || act_mode !== 2'b00 || c2ha_tready !== 1'b0 || c2h_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL normal_after: got c2h_cnt=%0d mode=%b rdy=%b vld=%b want 1 00 0 0",
               c2h_cnt, act_mode, c2ha_tready, c2h_tvalid);
    end
    h2c_tdata = 32'h1234_5678; h2c_tkeep = 4'hF; h2c_tlast = 1'b1; h2c_tvalid = 1'b1;
    h2ca_tready = 1'b0;
    #1;
    total++;
    if (h2ca_tvalid !== 1'b1 || h2c_tready !== 1'b0) begin
      bad++;
      $display("FAIL normal_h2c_stall: got h2ca_vld=%b h2c_rdy=%b want 1 0", h2ca_tvalid, h2c_tready);
    end
    @(negedge clk);
    h2ca_tready = 1'b1;
    #1;
    total++;
    if (h2c_tready !== 1'b1) begin
      bad++;
      $display("FAIL normal_h2c_rdy: got %b want 1", h2c_tready);
    end
    @(negedge clk);
    h2c_tvalid = 1'b0; h2c_tlast = 1'b0;
    #1;
    total++;
    if (h2c_cnt !== 3'd1) begin
      bad++;
      $display("FAIL normal_h2c_cnt: got %0d want 1", h2c_cnt);
    end
  endtask

  task automatic test_loopback();
    bit ok;
    set_mode(2'b01, 2'b01, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL lpbk_mode: got mode=%b busy=%b want 01 0", act_mode, busy);
    end
    pulse_clr();
    c2h_tready = 1'b1; h2ca_tready = 1'b1; c2ha_tvalid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      h2c_tdata = 32'(k); h2c_tkeep = 4'hF; h2c_tlast = (k == 7); h2c_tvalid = 1'b1;
      #1;
      total++;
      if (k == 0) begin
        if (c2h_tvalid !== 1'b0 || h2c_tready !== 1'b1) begin
          bad++;
          $display("FAIL lpbk_first: got c2h_vld=%b h2c_rdy=%b want 0 1", c2h_tvalid, h2c_tready);
        end
      end else if (c2h_tvalid !== 1'b1 || c2h_tdata !== 32'(k - 1) || c2h_tlast !== 1'b0 ||
                   h2c_tready !== 1'b1 || h2ca_tvalid !== 1'b0 || c2ha_tready !== 1'b0) begin
        bad++;
        $display("FAIL lpbk_beat %0d: got vld=%b data=%0d last=%b rdy=%b h2ca_vld=%b c2ha_rdy=%b want 1 %0d 0 1 0 0",
                 k, c2h_tvalid, c2h_tdata, c2h_tlast, h2c_tready, h2ca_tvalid, c2ha_tready, k - 1);
      end
    end
    @(negedge clk);
    h2c_tvalid = 1'b0; h2c_tlast = 1'b0; c2ha_tvalid = 1'b0;
    #1;
    total++;
    if (c2h_tvalid !== 1'b1 || c2h_tdata !== 32'd7 || c2h_tlast !== 1'b1) begin
      bad++;
      $display("FAIL lpbk_last: got vld=%b data=%0d last=%b want 1 7 1", c2h_tvalid, c2h_tdata, c2h_tlast);
    end
    @(negedge clk);
    #1;
    total++;
    if (c2h_tvalid !== 1'b0 || h2c_cnt !== 3'd1 || c2h_cnt !== 3'd1 || fifo_lvl !== 5'd0) begin
      bad++;
      $display("FAIL lpbk_done: got vld=%b h2c=%0d c2h=%0d lvl=%0d want 0 1 1 0",
               c2h_tvalid, h2c_cnt, c2h_cnt, fifo_lvl);
    end
  endtask

  task automatic test_fill();
    int sent = 0;
    int rcv = 0;
    c2h_tready = 1'b0;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      h2c_tdata = 32'(100 + sent); h2c_tkeep = 4'hF; h2c_tlast = (sent == 19); h2c_tvalid = 1'b1;
      #1;
      if (c == 20) begin
        total++;
        if (sent != 16 || fifo_lvl !== 5'd16 || h2c_tready !== 1'b0) begin
          bad++;
          $display("FAIL fill_full: got accepted=%0d lvl=%0d rdy=%b want 16 16 0", sent, fifo_lvl, h2c_tready);
        end
      end
      if (h2c_tvalid && h2c_tready) sent++;
    end
    for (int c = 0; c < 60 && rcv < 20; c++) begin
      @(negedge clk);
      c2h_tready = 1'b1;
      if (sent < 20) begin
        h2c_tdata = 32'(100 + sent); h2c_tlast = (sent == 19); h2c_tvalid = 1'b1;
      end else begin
        h2c_tvalid = 1'b0; h2c_tlast = 1'b0;
      end
      #1;
      if (c == 0) begin
        total++;
        if (h2c_tready !== 1'b1) begin
          bad++;
          $display("FAIL fill_full_rw: got h2c_rdy=%b want 1", h2c_tready);
        end
      end
      if (c == 1) begin
        total++;
        if (fifo_lvl !== 5'd16) begin
          bad++;
          $display("FAIL fill_lvl_rw: got %0d want 16", fifo_lvl);
        end
      end
      if (c2h_tvalid && c2h_tready) begin
        total++;
        if (c2h_tdata !== 32'(100 + rcv) || c2h_tlast !== (rcv == 19)) begin
          bad++;
          $display("FAIL fill_order %0d: got data=%0d last=%b want %0d %b",
                   rcv, c2h_tdata, c2h_tlast, 100 + rcv, rcv == 19);
        end
        rcv++;
      end
      if (h2c_tvalid && h2c_tready) sent++;
    end
    h2c_tvalid = 1'b0; h2c_tlast = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (rcv != 20 || h2c_cnt !== 3'd2 || c2h_cnt !== 3'd2 || fifo_lvl !== 5'd0) begin
      bad++;
      $display("FAIL fill_done: got rcv=%0d h2c=%0d c2h=%0d lvl=%0d want 20 2 2 0",
               rcv, h2c_cnt, c2h_cnt, fifo_lvl);
    end
  endtask

  task automatic test_mode_switch();
    bit ok;
    set_mode(2'b00, 2'b00, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL sw_to_norm: got mode=%b busy=%b want 00 0", act_mode, busy);
    end
    h2ca_tready = 1'b1; c2h_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      h2c_tdata = 32'(200 + i); h2c_tkeep = 4'hF; h2c_tlast = (i == 4); h2c_tvalid = 1'b1;
      if (i == 2) mode = 2'b01;
      if (i >= 3) begin
        c2ha_tdata = 32'hCAFE; c2ha_tlast = 1'b1; c2ha_tvalid = 1'b1;
      end
      #1;
      total++;
      if (h2ca_tvalid !== 1'b1 || h2c_tready !== 1'b1 || busy !== (i >= 3) ||
          (i >= 3 && (c2h_tvalid !== 1'b0 || c2ha_tready !== 1'b0))) begin
        bad++;
        $display("FAIL sw_beat %0d: got h2ca_vld=%b rdy=%b busy=%b c2h_vld=%b c2ha_rdy=%b want 1 1 %b 0 0",
                 i, h2ca_tvalid, h2c_tready, busy, c2h_tvalid, c2ha_tready, i >= 3);
      end
    end
    @(negedge clk);
    h2c_tdata = 32'hBAD; h2c_tlast = 1'b1; h2c_tvalid = 1'b1;
    #1;
    total++;
    if (busy !== 1'b1 || act_mode !== 2'b00 || h2c_tready !== 1'b0 || h2ca_tvalid !== 1'b0 ||
        c2h_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL sw_drain_block: got busy=%b mode=%b rdy=%b h2ca_vld=%b c2h_vld=%b want 1 00 0 0 0",
               busy, act_mode, h2c_tready, h2ca_tvalid, c2h_tvalid);
    end
    h2c_tvalid = 1'b0; h2c_tlast = 1'b0; c2ha_tvalid = 1'b0; c2ha_tlast = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || act_mode !== 2'b01 || h2c_cnt !== 3'd3 || fifo_lvl !== 5'd0) begin
      bad++;
      $display("FAIL sw_done: got busy=%b mode=%b h2c=%0d lvl=%0d want 0 01 3 0",
               busy, act_mode, h2c_cnt, fifo_lvl);
    end
  endtask

  task automatic test_counters();
    c2h_tready = 1'b1;
    @(negedge clk);
    h2c_tdata = 32'h55; h2c_tkeep = 4'hF; h2c_tlast = 1'b1; h2c_tvalid = 1'b1; cnt_clr = 1'b1;
    #1;
    total++;
    if (h2c_tready !== 1'b1) begin
      bad++;
      $display("FAIL clr_rdy: got %b want 1", h2c_tready);
    end
    @(negedge clk);
    h2c_tvalid = 1'b0; cnt_clr = 1'b0;
    #1;
    total++;
    if (h2c_cnt !== 3'd0) begin
      bad++;
      $display("FAIL clr_prio: got h2c=%0d want 0", h2c_cnt);
    end
    @(negedge clk);
    #1;
    total++;
    if (c2h_cnt !== 3'd1 || h2c_cnt !== 3'd0) begin
      bad++;
      $display("FAIL clr_after: got c2h=%0d h2c=%0d want 1 0", c2h_cnt, h2c_cnt);
    end
    pulse_clr();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      h2c_tdata = 32'(i); h2c_tlast = 1'b1; h2c_tvalid = 1'b1;
      if (i == 7) begin
        #1;
        total++;
        if (h2c_cnt !== 3'd7 || c2h_cnt !== 3'd6) begin
          bad++;
          $display("FAIL cnt_pre_wrap: got h2c=%0d c2h=%0d want 7 6", h2c_cnt, c2h_cnt);
        end
      end
    end
    @(negedge clk);
    h2c_tvalid = 1'b0; h2c_tlast = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (h2c_cnt !== 3'd0 || c2h_cnt !== 3'd0) begin
      bad++;
      $display("FAIL cnt_wrap: got h2c=%0d c2h=%0d want 0 0", h2c_cnt, c2h_cnt);
    end
  endtask

  task automatic test_drop();
    bit ok;
    set_mode(2'b10, 2'b10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drop_mode: got mode=%b busy=%b want 10 0", act_mode, busy);
    end
    h2ca_tready = 1'b0; c2h_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      h2c_tdata = 32'(300 + i); h2c_tlast = (i == 1); h2c_tvalid = 1'b1;
      c2ha_tdata = 32'hDEAD_BEEF; c2ha_tkeep = 4'h7; c2ha_tlast = 1'b1; c2ha_tvalid = (i == 0);
      #1;
      total++;
      if (h2c_tready !== 1'b1 || h2ca_tvalid !== 1'b0 ||
          (i == 0 && (c2h_tvalid !== 1'b1 || c2h_tdata !== 32'hDEAD_BEEF || c2h_tkeep !== 4'h7))) begin
        bad++;
        $display("FAIL drop_beat %0d: got rdy=%b h2ca_vld=%b c2h_vld=%b data=%h keep=%h want 1 0 %b deadbeef 7",
                 i, h2c_tready, h2ca_tvalid, c2h_tvalid, c2h_tdata, c2h_tkeep, i == 0);
      end
    end
    @(negedge clk);
    h2c_tvalid = 1'b0; h2c_tlast = 1'b0; c2ha_tvalid = 1'b0; c2ha_tlast = 1'b0;
    #1;
    total++;
    if (h2c_cnt !== 3'd1 || c2h_cnt !== 3'd1) begin
      bad++;
      $display("FAIL drop_cnt: got h2c=%0d c2h=%0d want 1 1", h2c_cnt, c2h_cnt);
    end
    set_mode(2'b11, 2'b00, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL mode11_norm: got mode=%b busy=%b want 00 0", act_mode, busy);
    end
  endtask

  task automatic test_err();
    bit ok;
    logic err_exp;
`ifdef USR_LPBK_ERR_CHK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    set_mode(2'b01, 2'b01, ok);
    pulse_clr();
    c2h_tready = 1'b1;
    @(negedge clk);
    h2c_tdata = 32'h0000_00AB; h2c_tkeep = 4'h3; h2c_tlast = 1'b0; h2c_tvalid = 1'b1;
    @(negedge clk);
    h2c_tkeep = 4'hF; h2c_tlast = 1'b1;
    #1;
    total++;
    if (!ok || err !== err_exp || c2h_tvalid !== 1'b1 || c2h_tkeep !== 4'h3) begin
      bad++;
      $display("FAIL err_set: got ok=%b err=%b c2h_vld=%b keep=%h want 1 %b 1 3",
               ok, err, c2h_tvalid, c2h_tkeep, err_exp);
    end
    @(negedge clk);
    h2c_tvalid = 1'b0; h2c_tlast = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (err !== err_exp) begin
      bad++;
      $display("FAIL err_sticky: got %b want %b", err, err_exp);
    end
    pulse_clr();
    #1;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: got %b want 0", err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal();
    test_loopback();
    test_fill();
    test_mode_switch();
    test_counters();
    test_drop();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
